// File: rtl/npu_load_sequencer_pkg.sv
// npu_pkg: shared types and default sizes for the NPU host load sequencer.
//   region_e : destination model-memory region (IMG..D2), 3-bit code on wr_region_o
//   state_e  : sequencer FSM state; the L_* states are laid out in region order
//              so a region maps to its load state by a constant offset
//   *_DEF    : default per-region word counts and region address width
package npu_pkg;

  localparam int unsigned IMG_WORDS_DEF = 224;
  localparam int unsigned C12_WORDS_DEF = 320;
  localparam int unsigned C34_WORDS_DEF = 9248;
  localparam int unsigned C5_WORDS_DEF  = 9247;
  localparam int unsigned D1_WORDS_DEF  = 4104;
  localparam int unsigned D2_WORDS_DEF  = 99;
  localparam int unsigned AW_DEF        = 14;
  localparam int          NUM_REGIONS   = 6;

  typedef enum logic [2:0] {
    R_IMG = 3'd0,
    R_C12 = 3'd1,
    R_C34 = 3'd2,
    R_C5  = 3'd3,
    R_D1  = 3'd4,
    R_D2  = 3'd5
  } region_e;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_L_IMG  = 4'd1,
    S_L_C12  = 4'd2,
    S_L_C34  = 4'd3,
    S_L_C5   = 4'd4,
    S_L_D1   = 4'd5,
    S_L_D2   = 4'd6,
    S_LOADED = 4'd7,
    S_RUN    = 4'd8
  } state_e;

  // Conv parameter regions carry one byte per host word.
  function automatic logic is_byte_region(input region_e r);
    return (r == R_C12) || (r == R_C34) || (r == R_C5);
  endfunction

  function automatic state_e load_state(input region_e r);
    return state_e'(4'(r) + 4'(S_L_IMG));
  endfunction

endpackage

// File: rtl/npu_load_sequencer_seg_counter.sv
// seg_counter: word index within the current load region.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : force the count back to 0 (aborted load)
//   en_i           : one accepted word this cycle
//   limit_i        : terminal count (region size - 1)
//   cnt_o          : index of the word being accepted this cycle
//   wrap_o         : this accepted word is the last of the region; count returns to 0
module seg_counter #(
  parameter int unsigned AW = 14
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [AW-1:0] limit_i,
  output logic [AW-1:0] cnt_o,
  output logic          wrap_o
);

  logic [AW-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == limit_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = wrap_o ? '0 : cnt_q + AW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/npu_load_sequencer.sv
// npu_load_sequencer: host-side front end of mem_top. Steers the host write
// stream into the six model-memory regions in fixed order, then arms a
// one-cycle inference start pulse.
//   clk_i, reset_i  : clock, synchronous active-high reset
//   write_i         : host word valid
//   writedata_i     : host word
//   control_reg_i   : [0] load mode, [1] start request (edge-qualified), rest ignored
//   wr_en_o         : registered write strobe to mem_top (1 cycle after write_i)
//   wr_region_o     : region code of the strobed word (region_e)
//   wr_addr_o       : word index within that region
//   wr_data_o       : registered copy of writedata_i
//   wr_byte_o       : region holds byte entries (only [7:0] meaningful)
//   load_done_o     : high while the load is complete and awaiting start
//   start_o         : one-cycle inference start pulse
//   seq_err_o       : sticky protocol error, cleared by reset or a new load
// Optional feature, macro NPU_LOAD_CHECKSUM_EN:
//   load_sum_o      : mod-2^32 sum of accepted words of the current load
module npu_load_sequencer
  import npu_pkg::*;
#(
  parameter int unsigned IMG_WORDS = IMG_WORDS_DEF,
  parameter int unsigned C12_WORDS = C12_WORDS_DEF,
  parameter int unsigned C34_WORDS = C34_WORDS_DEF,
  parameter int unsigned C5_WORDS  = C5_WORDS_DEF,
  parameter int unsigned D1_WORDS  = D1_WORDS_DEF,
  parameter int unsigned D2_WORDS  = D2_WORDS_DEF,
  parameter int unsigned AW        = AW_DEF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          write_i,
  input  logic [31:0]   writedata_i,
  input  logic [31:0]   control_reg_i,
  output logic          wr_en_o,
  output logic [2:0]    wr_region_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [31:0]   wr_data_o,
  output logic          wr_byte_o,
  output logic          load_done_o,
  output logic          start_o,
  output logic          seq_err_o
`ifdef NPU_LOAD_CHECKSUM_EN
  ,
  output logic [31:0]   load_sum_o
`endif
);

  function automatic int unsigned seg_words(input region_e r);
    case (r)
      R_IMG:   return IMG_WORDS;
      R_C12:   return C12_WORDS;
      R_C34:   return C34_WORDS;
      R_C5:    return C5_WORDS;
      R_D1:    return D1_WORDS;
      R_D2:    return D2_WORDS;
      default: return 0;
    endcase
  endfunction

  // First load state at or after region 'from' with a nonzero size; empty
  // regions are skipped within the same transition. Past D2 means LOADED.
  function automatic state_e first_live(input int from);
    state_e s;
    s = S_LOADED;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if (i >= from && seg_words(region_e'(i[2:0])) != 0)
        s = load_state(region_e'(i[2:0]));
    return s;
  endfunction

  state_e        state_q, state_d;
  region_e       cur_reg, region_q;
  logic          in_load, accept, abort, fresh, start_req, err_set;
  logic          bit1_q, wrap;
  logic [AW-1:0] cnt, limit;
  logic          wr_en_q, byte_q, load_done_q, start_q, seq_err_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic          unused_ctrl;

  assign unused_ctrl = ^control_reg_i[31:2];

  assign in_load = state_q inside {S_L_IMG, S_L_C12, S_L_C34, S_L_C5, S_L_D1, S_L_D2};
  assign cur_reg = region_e'(3'(state_q - S_L_IMG));
  assign limit   = AW'(seg_words(cur_reg) - 1);

  assign accept    = in_load && write_i && control_reg_i[0];
  assign abort     = in_load && !control_reg_i[0];
  // Load mode from any resting state starts over at IMG.
  assign fresh     = !in_load && control_reg_i[0];
  // Start is taken on the rising edge of bit1 only, so a held bit1 cannot
  // re-fire once the FSM returns to LOADED.
  assign start_req = control_reg_i[1] && !bit1_q;

  // A start request is an error unless it is honoured (LOADED, and not
  // overridden by a simultaneous load request).
  assign err_set = abort
                || (state_q == S_LOADED && write_i)
                || (start_req && (state_q != S_LOADED || control_reg_i[0]));

  seg_counter #(.AW(AW)) u_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (abort),
    .en_i    (accept),
    .limit_i (limit),
    .cnt_o   (cnt),
    .wrap_o  (wrap)
  );

  always_comb begin
    state_d = state_q;
    if (in_load) begin
      if (abort)     state_d = S_IDLE;
      else if (wrap) state_d = first_live(int'(cur_reg) + 1);
    end else if (fresh) begin
      state_d = first_live(0);
    end else if (state_q == S_LOADED && start_req) begin
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      bit1_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      region_q    <= R_IMG;
      addr_q      <= '0;
      data_q      <= '0;
      byte_q      <= 1'b0;
      load_done_q <= 1'b0;
      start_q     <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit1_q      <= control_reg_i[1];
      wr_en_q     <= accept;
      if (accept) begin
        region_q <= cur_reg;
        addr_q   <= cnt;
        data_q   <= writedata_i;
        byte_q   <= is_byte_region(cur_reg);
      end
      // Registered against the next state so load_done rises with the
      // strobe of the final D2 word.
      load_done_q <= (state_d == S_LOADED);
      start_q     <= (state_q == S_LOADED) && start_req && !control_reg_i[0];
      // Error set wins over the clear of a new load.
      seq_err_q   <= (fresh ? 1'b0 : seq_err_q) | err_set;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_region_o = region_q;
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = data_q;
  assign wr_byte_o   = byte_q;
  assign load_done_o = load_done_q;
  assign start_o     = start_q;
  assign seq_err_o   = seq_err_q;

`ifdef NPU_LOAD_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)     sum_q <= '0;
    else if (fresh)  sum_q <= '0;
    else if (accept) sum_q <= sum_q + writedata_i;
  end

  assign load_sum_o = sum_q;
`endif

endmodule

// File: tb/tb_npu_load_sequencer.sv
module tb_npu_load_sequencer;
  import npu_pkg::*;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst, wr;
  logic [31:0]   wd, cr;

  logic          b_en, b_byte, b_done, b_start, b_err;
  logic [2:0]    b_reg;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_data;
  logic          s_en, s_byte, s_done, s_start, s_err;
  logic [2:0]    s_reg;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_data;
`ifdef NPU_LOAD_CHECKSUM_EN
  logic [31:0]   b_sum, s_sum;
`endif

  always #5 clk = ~clk;

  npu_load_sequencer #(.AW(AW)) u_big (
    .clk_i(clk), .reset_i(rst), .write_i(wr), .writedata_i(wd), .control_reg_i(cr),
    .wr_en_o(b_en), .wr_region_o(b_reg), .wr_addr_o(b_addr), .wr_data_o(b_data),
    .wr_byte_o(b_byte), .load_done_o(b_done), .start_o(b_start), .seq_err_o(b_err)
`ifdef NPU_LOAD_CHECKSUM_EN
    , .load_sum_o(b_sum)
`endif
  );

  // Small image with an empty C12 region.
  npu_load_sequencer #(.IMG_WORDS(3), .C12_WORDS(0), .C34_WORDS(2), .C5_WORDS(1),
                       .D1_WORDS(2), .D2_WORDS(1), .AW(AW)) u_small (
    .clk_i(clk), .reset_i(rst), .write_i(wr), .writedata_i(wd), .control_reg_i(cr),
    .wr_en_o(s_en), .wr_region_o(s_reg), .wr_addr_o(s_addr), .wr_data_o(s_data),
    .wr_byte_o(s_byte), .load_done_o(s_done), .start_o(s_start), .seq_err_o(s_err)
`ifdef NPU_LOAD_CHECKSUM_EN
    , .load_sum_o(s_sum)
`endif
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the load as a single global word index and derives region and
  // address from cumulative region sizes.
  int          mid;
  int          m_sz[6];
  int          m_total, m_phase, m_k;   // phase: 0 idle, 1 loading, 2 loaded, 3 run
  bit          m_prev1, m_err;
  logic [31:0] m_sum;
  bit          e_en, e_byte, e_start, e_done;
  int          e_reg, e_addr;
  logic [31:0] e_data;

  task automatic model_init(input int id);
    mid = id;
    if (id == 0) m_sz = '{224, 320, 9248, 9247, 4104, 99};
    else         m_sz = '{3, 0, 2, 1, 2, 1};
    m_total = 0;
    for (int i = 0; i < 6; i++) m_total += m_sz[i];
    m_phase = 0; m_k = 0; m_prev1 = 0; m_err = 0; m_sum = 0;
  endtask

  task automatic step(input bit c0, input bit c1, input bit w, input logic [31:0] d);
    bit sreq, e;
    int r, base;
    logic a_en, a_byte, a_done, a_start, a_err;
    logic [2:0] a_reg;
    logic [AW-1:0] a_addr;
    logic [31:0] a_data;
    cr = {30'b0, c1, c0}; wr = w; wd = d;
    e_en = 0; e_start = 0;
    sreq = c1 && !m_prev1;
    m_prev1 = c1;
    if (m_phase == 1) begin
      if (!c0) begin
        m_phase = 0; m_k = 0; m_err = 1;
      end else begin
        if (sreq) m_err = 1;
        if (w) begin
          r = 0; base = 0;
          while (m_k >= base + m_sz[r]) begin base += m_sz[r]; r++; end
          e_en = 1; e_reg = r; e_addr = m_k - base; e_data = d;
          e_byte = (r >= 1 && r <= 3);
          m_sum += d; m_k++;
          if (m_k == m_total) m_phase = 2;
        end
      end
    end else begin
      e = (m_phase == 2 && w) || (sreq && (m_phase != 2 || c0));
      if (c0) begin
        m_err = e; m_phase = 1; m_k = 0; m_sum = 0;
      end else begin
        m_err = m_err | e;
        if (sreq && m_phase == 2) begin e_start = 1; m_phase = 3; end
      end
    end
    e_done = (m_phase == 2);
    @(posedge clk); #1;
    if (mid == 0) begin
      a_en = b_en; a_byte = b_byte; a_done = b_done; a_start = b_start; a_err = b_err;
      a_reg = b_reg; a_addr = b_addr; a_data = b_data;
    end else begin
      a_en = s_en; a_byte = s_byte; a_done = s_done; a_start = s_start; a_err = s_err;
      a_reg = s_reg; a_addr = s_addr; a_data = s_data;
    end
    chk("m_wr_en", 32'(a_en), 32'(e_en));
    chk("m_load_done", 32'(a_done), 32'(e_done));
    chk("m_start", 32'(a_start), 32'(e_start));
    chk("m_seq_err", 32'(a_err), 32'(m_err));
    if (e_en) begin
      chk("m_region", 32'(a_reg), 32'(e_reg));
      chk("m_addr", 32'(a_addr), 32'(e_addr));
      chk("m_data", a_data, e_data);
      chk("m_byte", 32'(a_byte), 32'(e_byte));
    end
`ifdef NPU_LOAD_CHECKSUM_EN
    chk("m_load_sum", (mid == 0) ? b_sum : s_sum, m_sum);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_big_ctl"}, {10'b0, b_en, b_done, b_start, b_err, b_byte, b_reg, b_addr}, 32'h0);
    chk({tag, "_big_data"}, b_data, 32'h0);
    chk({tag, "_small_ctl"}, {10'b0, s_en, s_done, s_start, s_err, s_byte, s_reg, s_addr}, 32'h0);
    chk({tag, "_small_data"}, s_data, 32'h0);
`ifdef NPU_LOAD_CHECKSUM_EN
    chk({tag, "_big_sum"}, b_sum, 32'h0);
    chk({tag, "_small_sum"}, s_sum, 32'h0);
`endif
  endtask

  task automatic do_reset();
    rst = 1; cr = 0; wr = 0; wd = 0;
    @(posedge clk); #1;
    rst = 0;
    check_zero("reset");
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rst, c0, c1, w;
    logic [31:0] d;
    bit en;
    int rg, ad;
    bit done, st, err;
  } vec_t;

  function automatic vec_t mk(bit rst_, bit c0, bit c1, bit w, logic [31:0] d, bit en,
                              int rg, int ad, bit done, bit st, bit err);
    vec_t v;
    v.rst = rst_; v.c0 = c0; v.c1 = c1; v.w = w; v.d = d; v.en = en;
    v.rg = rg; v.ad = ad; v.done = done; v.st = st; v.err = err;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int exp_rg[9] = '{0, 0, 0, 2, 2, 3, 4, 4, 5};
    int exp_ad[9] = '{0, 1, 2, 0, 1, 0, 0, 1, 0};
    int bnd[6]    = '{0, 224, 544, 9792, 19039, 23143};
    int n_st, n_s;
    bit c0, c1;

    rst = 1; cr = 0; wr = 0; wd = 0;

    // Small DUT: full load with C12 skipped, error and start handling.
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'hA0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'hFF, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'hA1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'hA2, 1, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'hA3, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'hA4, 1, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'hA5, 1, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'hA6, 1, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'hA7, 1, 4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'hA8, 1, 5, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'hB0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 32'hC0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 32'hC1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0));
    for (int j = 0; j < 9; j++)
      tbl.push_back(mk(0, 1, 0, 1, 32'hD0 + 32'(j), 1, exp_rg[j], exp_ad[j], j == 8, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,  0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; cr = {30'b0, tbl[i].c1, tbl[i].c0}; wr = tbl[i].w; wd = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_en", i), 32'(s_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_done", i), 32'(s_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_start", i), 32'(s_start), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_err", i), 32'(s_err), 32'(tbl[i].err));
      if (tbl[i].en) begin
        chk($sformatf("tbl%0d_region", i), 32'(s_reg), 32'(tbl[i].rg));
        chk($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(tbl[i].ad));
        chk($sformatf("tbl%0d_data", i), s_data, tbl[i].d);
        chk($sformatf("tbl%0d_byte", i), 32'(s_byte), 32'(tbl[i].rg >= 1 && tbl[i].rg <= 3));
      end
    end
    rst = 0;

    // Big DUT, full load with continuous writes.
    model_init(0);
    do_reset();
    step(1, 0, 0, 32'h0);
    for (int k = 0; k < 23242; k++) begin
      step(1, 0, 1, $urandom);
      for (int j = 0; j < 6; j++)
        if (k == bnd[j]) begin
          chk("boundary_region", 32'(b_reg), 32'(j));
          chk("boundary_addr", 32'(b_addr), 32'h0);
        end
      if (k == 23240) chk("done_before_last", 32'(b_done), 32'h0);
    end
    chk("full_load_done", 32'(b_done), 32'h1);
    chk("full_load_err", 32'(b_err), 32'h0);

    // Start held for 5 cycles gives a single pulse.
    step(0, 0, 0, 32'h0);
    n_st = 0;
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 32'h0);
      if (b_start) n_st++;
    end
    chk("start_pulse_count", 32'(n_st), 32'h1);
    step(0, 0, 0, 32'h0);
    chk("run_done_low", 32'(b_done), 32'h0);

    // Reset in the middle of C34 at count 100.
    step(1, 0, 0, 32'h0);
    for (int k = 0; k < 644; k++) step(1, 0, 1, $urandom);
    chk("pre_reset_c34_addr", 32'(b_addr), 32'd99);
    rst = 1; cr = 32'h1; wr = 1; wd = 32'h1234_5678;
    @(posedge clk); #1;
    rst = 0;
    check_zero("midload_reset");
    model_init(0);
    step(1, 0, 0, 32'h0);
    step(1, 0, 1, 32'h0BAD_F00D);
    chk("restart_region", 32'(b_reg), 32'h0);
    chk("restart_addr", 32'(b_addr), 32'h0);

    // Toggling write through IMG: 224 strobes, then C12 address 0.
    n_s = 1;
    for (int k = 0; k < 446; k++) begin
      step(1, 0, k % 2 == 1, $urandom);
      if (b_en) begin
        chk("toggle_addr", 32'(b_addr), 32'(n_s));
        n_s++;
      end
    end
    chk("img_strobes", 32'(n_s), 32'd224);
    step(1, 0, 1, $urandom);
    chk("after_img_region", 32'(b_reg), 32'h1);
    chk("after_img_addr", 32'(b_addr), 32'h0);

    // Load mode dropped at D1 word 10.
    for (int k = 225; k < 19049; k++) step(1, 0, 1, $urandom);
    chk("d1_word9_region", 32'(b_reg), 32'h4);
    chk("d1_word9_addr", 32'(b_addr), 32'd9);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, $urandom);
      chk("abort_no_strobe", 32'(b_en), 32'h0);
      chk("abort_err", 32'(b_err), 32'h1);
    end

    // Randomized traffic on the small DUT.
    model_init(1);
    do_reset();
    c0 = 0; c1 = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(24) == 0) c0 = ~c0;
      if (m_phase == 2 && $urandom_range(1) == 0) c0 = 0;
      if ($urandom_range(7) == 0) c1 = ~c1;
      step(c0, c1, $urandom_range(3) != 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
